// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the unified-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding core and memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Fetch requester
    logic              instr_req_ip;
    logic [ADDR_W-1:0] instr_addr_ip;
    logic              instr_gnt_op;
    logic              instr_rvalid_op;
    logic [DATA_W-1:0] instr_rdata_op;

    // Load/store requester
    logic              data_req_ip;
    logic              data_we_ip;
    logic [BE_W-1:0]   data_be_ip;
    logic [ADDR_W-1:0] data_addr_ip;
    logic [DATA_W-1:0] data_wdata_ip;
    logic              data_gnt_op;
    logic              data_rvalid_op;
    logic [DATA_W-1:0] data_rdata_op;

    // Memory port
    logic              mem_req_op;
    logic              mem_we_op;
    logic [BE_W-1:0]   mem_be_op;
    logic [ADDR_W-1:0] mem_addr_op;
    logic [DATA_W-1:0] mem_wdata_op;
    logic              mem_rvalid_ip;
    logic [DATA_W-1:0] mem_rdata_ip;

    logic              busy_op;

    // Handshake: a requester raises req and holds it with stable fields until
    // the cycle its gnt is 1; the transfer is accepted at that rising edge.
    // The response is a one-cycle rvalid pulse; there is no back-pressure on it.
    modport slave (
        input  instr_req_ip, instr_addr_ip,
        output instr_gnt_op, instr_rvalid_op, instr_rdata_op,
        input  data_req_ip, data_we_ip, data_be_ip, data_addr_ip, data_wdata_ip,
        output data_gnt_op, data_rvalid_op, data_rdata_op,
        output mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
        input  mem_rvalid_ip, mem_rdata_ip,
        output busy_op
    );

    modport master (
        output instr_req_ip, instr_addr_ip,
        input  instr_gnt_op, instr_rvalid_op, instr_rdata_op,
        output data_req_ip, data_we_ip, data_be_ip, data_addr_ip, data_wdata_ip,
        input  data_gnt_op, data_rvalid_op, data_rdata_op,
        input  mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
        output mem_rvalid_ip, mem_rdata_ip,
        input  busy_op
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one single-port memory, one transaction in
// flight, data first, with a starvation counter that periodically forces a fetch.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    mem_port_arbiter_if.slave                    bus,
    output logic                                 state_dbg_op,
    output logic [$clog2(STARVE_LIMIT+1)-1:0]    starve_cnt_dbg_op
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;
    typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              load_q, load_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              instr_rvalid_q, instr_rvalid_d;
    logic              data_rvalid_q, data_rvalid_d;
    logic [DATA_W-1:0] instr_rdata_q, instr_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

    logic              instr_win;
    logic              data_win;
    logic              grant;
    logic              resp;
    logic              win_we;
    logic [BE_W-1:0]   win_be;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // Winner selection; suppressed outside IDLE and while reset is held low.
    always_comb begin
        instr_win = 1'b0;
        data_win  = 1'b0;
        if (reset && (state_q == ST_IDLE)) begin
            instr_win = bus.instr_req_ip &&
                        (!bus.data_req_ip || (starve_cnt_q == CNT_MAX));
            data_win  = bus.data_req_ip && !instr_win;
        end
    end

    assign grant = instr_win || data_win;
    assign resp  = (state_q == ST_WAIT) && bus.mem_rvalid_ip;

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant) state_d = ST_WAIT;
            ST_WAIT: if (bus.mem_rvalid_ip) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: grants and the combinational memory request mux
    always_comb begin
        win_we    = 1'b0;
        win_be    = '0;
        win_addr  = '0;
        win_wdata = '0;
        if (instr_win) begin
            win_be   = '1;
            win_addr = bus.instr_addr_ip;
        end else if (data_win) begin
            win_we    = bus.data_we_ip;
            win_be    = bus.data_be_ip;
            win_addr  = bus.data_addr_ip;
            win_wdata = bus.data_wdata_ip;
        end
        bus.instr_gnt_op = instr_win;
        bus.data_gnt_op  = data_win;
        bus.mem_req_op   = grant;
        bus.mem_we_op    = win_we;
        bus.mem_be_op    = win_be;
        bus.mem_addr_op  = win_addr;
        bus.mem_wdata_op = win_wdata;
        bus.busy_op      = (state_q == ST_WAIT);
        state_dbg_op     = state_q;
    end

    // Owner tracking, starvation counting and response capture
    always_comb begin
        owner_d        = owner_q;
        load_d         = load_q;
        starve_cnt_d   = starve_cnt_q;
        instr_rvalid_d = 1'b0;
        data_rvalid_d  = 1'b0;
        instr_rdata_d  = instr_rdata_q;
        data_rdata_d   = data_rdata_q;

        if (state_q == ST_IDLE) begin
            if (instr_win) begin
                owner_d      = OWN_INSTR;
                load_d       = 1'b1;
                starve_cnt_d = '0;
            end else if (data_win) begin
                owner_d = OWN_DATA;
                load_d  = !bus.data_we_ip;
                if (bus.instr_req_ip && (starve_cnt_q != CNT_MAX)) begin
                    starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end
            end
            // A fetch that is not waiting has nothing to be starved of.
            if (!bus.instr_req_ip) begin
                starve_cnt_d = '0;
            end
        end

        if (resp) begin
            if (owner_q == OWN_INSTR) begin
                instr_rvalid_d = 1'b1;
                instr_rdata_d  = bus.mem_rdata_ip;
            end else begin
                data_rvalid_d = 1'b1;
                if (load_q) begin
                    data_rdata_d = bus.mem_rdata_ip;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            owner_q        <= OWN_INSTR;
            load_q         <= 1'b1;
            starve_cnt_q   <= '0;
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            instr_rdata_q  <= '0;
            data_rdata_q   <= '0;
        end else begin
            owner_q        <= owner_d;
            load_q         <= load_d;
            starve_cnt_q   <= starve_cnt_d;
            instr_rvalid_q <= instr_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
            instr_rdata_q  <= instr_rdata_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    assign bus.instr_rvalid_op = instr_rvalid_q;
    assign bus.instr_rdata_op  = instr_rdata_q;
    assign bus.data_rvalid_op  = data_rvalid_q;
    assign bus.data_rdata_op   = data_rdata_q;
    assign starve_cnt_dbg_op   = starve_cnt_q;

    a_one_grant: assert property (@(posedge clock) disable iff (!reset)
        !(bus.instr_gnt_op && bus.data_gnt_op));
    a_no_grant_busy: assert property (@(posedge clock) disable iff (!reset)
        (state_q == ST_WAIT) |-> !bus.mem_req_op);
    a_one_rvalid: assert property (@(posedge clock) disable iff (!reset)
        !(bus.instr_rvalid_op && bus.data_rvalid_op));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester and the load/store (MEM stage) requester.
- Accepts at most one outstanding transaction and routes the memory response back to the requester that owns it.
- Data requests have priority, since they belong to the older instruction.
- A starvation counter periodically forces an instruction grant so the fetch side cannot be locked out.

Parameters:
ADDR_W, 32, address width of requesters and memory
DATA_W, 32, data width; byte-enable width is DATA_W/8
STARVE_LIMIT, 4, consecutive data grants with a pending instr request before instr is forced to win (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
instr_req_ip  in  1  fetch request, held until granted
instr_addr_ip  in  ADDR_W  fetch address
instr_gnt_op  out  1  fetch request accepted this cycle
instr_rvalid_op  out  1  one-cycle pulse, fetch data valid
instr_rdata_op  out  DATA_W  fetched instruction
data_req_ip  in  1  load/store request, held until granted
data_we_ip  in  1  1=store, 0=load
data_be_ip  in  DATA_W/8  store byte enables
data_addr_ip  in  ADDR_W  load/store address
data_wdata_ip  in  DATA_W  store data
data_gnt_op  out  1  load/store accepted this cycle
data_rvalid_op  out  1  one-cycle pulse, load data or store ack
data_rdata_op  out  DATA_W  load data
mem_req_op  out  1  request to memory
mem_we_op  out  1  write enable to memory
mem_be_op  out  DATA_W/8  byte enables to memory
mem_addr_op  out  ADDR_W  address to memory
mem_wdata_op  out  DATA_W  write data to memory
mem_rvalid_ip  in  1  memory response or ack, any latency >=1 cycle
mem_rdata_ip  in  DATA_W  memory read data
busy_op  out  1  transaction outstanding

Behaviour:
- Reset (reset==0 at a rising edge):
  - State becomes IDLE; owner=INSTR; starve_cnt=0.
  - Both rvalid outputs are 0; both rdata outputs are 0.
  - All gnt outputs and mem_* outputs are 0 while reset is low.
- FSM has two states: IDLE and WAIT. busy_op = (state==WAIT).
- IDLE, winner selection (combinational):
  - instr wins if instr_req_ip && (!data_req_ip || starve_cnt==STARVE_LIMIT).
  - Otherwise data wins if data_req_ip.
- IDLE, when a winner exists:
  - The winner's gnt_op is 1 in the same cycle.
  - mem_req_op=1, and mem_addr/we/be/wdata are muxed combinationally from the winner.
  - Instr grants drive mem_we_op=0 and mem_be_op all-ones.
  - At the clock edge: owner is latched and state goes to WAIT.
- IDLE with no request: all gnt=0, mem_req_op=0, mem_* data outputs are 0.
- starve_cnt, updated at the edge in IDLE:
  - Data grant while instr_req_ip is high: increment, saturating at STARVE_LIMIT.
  - Instr grant: clear to 0.
  - instr_req_ip low: clear to 0.
  - It is unchanged while in WAIT.
- WAIT:
  - mem_req_op=0 and all gnt=0; new requests stay pending (requesters hold them).
  - On a cycle with mem_rvalid_ip=1: at that edge state goes to IDLE.
  - Same edge, owner INSTR: instr_rvalid_op is set to 1 and instr_rdata_op captures mem_rdata_ip.
  - Same edge, owner DATA: data_rvalid_op is set to 1 and data_rdata_op captures mem_rdata_ip on loads only. Stores leave data_rdata_op unchanged but still pulse rvalid.
- rvalid outputs are registered, one-cycle pulses. rdata holds until the next response to the same owner.
- Response latency to the requester is one cycle after mem_rvalid_ip.
- Back-to-back: the cycle after a response is IDLE, so a new grant can occur there. Minimum issue interval is memory latency + 1 cycles.
- mem_rvalid_ip while in IDLE is ignored: no rvalid pulse, no state change.
- Reset during WAIT abandons the transaction: no rvalid pulse is ever produced for it, and a late mem_rvalid_ip lands in IDLE and is ignored.
- A request that drops before its grant is a protocol violation and carries no required behaviour.

Test Plan:
- Fetch only, addr 0x100, memory latency 2, rdata 0x00500093 -> instr_gnt_op in cycle 0, mem_addr_op=0x100, mem_we_op=0; instr_rvalid_op in cycle 3 with rdata=0x00500093; busy_op high in cycles 1-2.
- instr_req and data_req (load, addr 0x2000) together in IDLE, starve_cnt=0 -> data_gnt_op=1, instr_gnt_op=0; after the data response, instr is granted the next IDLE cycle; starve_cnt=1 then 0.
- Both requests held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Load to 0x40 returns 0xDEADBEEF, then store be=4'b0011 wdata=0x1234 -> mem_be_op=0011; data_rvalid_op pulses both times; data_rdata_op stays 0xDEADBEEF after the store.
- Reset low for 1 cycle during WAIT; memory asserts rvalid 2 cycles later -> no rvalid pulse on either port; busy_op=0; outputs are at reset values.
- mem_rvalid_ip pulsed in IDLE with mem_rdata_ip=0xFFFFFFFF -> no rvalid pulse; both rdata outputs unchanged.
